// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock to request to send, then shifts
// start/data/parity/stop on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned clock_filter   = 24,
  parameter int unsigned inhibit_cycles = 12000,
  parameter int unsigned timeout_cycles = 2400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);
  localparam int unsigned FW = $clog2(clock_filter) + 1;
  localparam int unsigned IW = $clog2(inhibit_cycles) + 1;
  localparam int unsigned TW = $clog2(timeout_cycles) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(clock_filter - 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(inhibit_cycles - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(timeout_cycles - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAITIDLE} state_t;

  // Line conditioning: index 0 = PS2_CLK, index 1 = PS2_DATA.
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic               fall_q, fall_d;

  state_t        state_q, state_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          done_q, done_d, error_q, error_d;
  logic          busy_q, busy_d, ready_q, ready_d;

  always_comb begin
    sync1_d = {ps2_dat_in, ps2_clk_in};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fcnt_d  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = sync2_q[i];
        else fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
    fall_d = filt_q[0] & ~filt_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          frame_d   = {1'b1, ~^tx_byte, tx_byte};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          to_cnt_d = '0;
          state_d  = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      REQ, SHIFT, ACK, WAITIDLE: begin
        // Timeout is checked first so it wins over a coincident fall strobe.
        if (to_cnt_q == TO_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if ((state_q == REQ || state_q == SHIFT) && fall_q) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            dat_oe_d  = ~frame_q[0];
            frame_d   = {1'b0, frame_q[9:1]};
            state_d   = (bit_cnt_q == 4'd9) ? ACK : SHIFT;
          end else if (state_q == ACK && fall_q) begin
            if (!filt_q[1]) begin
              state_d = WAITIDLE;
            end else begin
              error_d  = 1'b1;
              clk_oe_d = 1'b0;
              dat_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end else if (state_q == WAITIDLE && filt_q[0] && filt_q[1]) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign busy       = busy_q;
  assign tx_ready   = ready_q;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends command bytes (LED updates, reset, typematic settings) to the keyboard over the same open-drain PS2_CLK/PS2_DATA pins that the receive path listens on. It sits beside the PS/2 receiver, downstream of keyboard_ps2, which issues the command bytes. It drives the pins only through active-high pull-low enables; the top level turns these into tristate buffers. While a transfer is in progress it asserts `busy` so the receiver can discard line activity.

## Interface
- `clock_filter`, 24: number of consecutive stable samples a synchronized PS/2 line must show before its filtered level changes.
- `inhibit_cycles`, 12000: clocks for which PS2_CLK is held low to request to send (at least 100 µs).
- `timeout_cycles`, 2400000: clocks allowed from the start of the request phase to ACK sampling (about 20 ms).
- `clk`  in  1  system clock. The only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk_in`  in  1  raw PS2_CLK pin level (asynchronous).
- `ps2_dat_in`  in  1  raw PS2_DATA pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull PS2_CLK low.
- `ps2_dat_oe`  out  1  1 = pull PS2_DATA low.
- `tx_byte`  in  8  command byte, [7:0], sent LSB first.
- `tx_valid`  in  1  request to send `tx_byte`.
- `tx_ready`  out  1  block can accept a byte.
- `tx_done`  out  1  one-cycle pulse: device acknowledged.
- `tx_error`  out  1  one-cycle pulse: timeout, or ACK bit read as 1.
- `busy`  out  1  high from acceptance until return to IDLE.

## Operation
- **Input conditioning.** Each line passes through a 2-FF synchronizer and then a filter counter. The filtered level takes the synchronized value after `clock_filter` consecutive equal samples. `fall` is a one-cycle strobe when the filtered clock goes from 1 to 0. Filtered levels reset to 1.
- **IDLE.**
  - Both oe = 0, `tx_ready` = 1.
  - On `tx_valid & tx_ready`: latch the byte, compute odd parity (`~^tx_byte`), clear the bit counter, and go to INHIBIT.
- **INHIBIT.**
  - `ps2_clk_oe` = 1 for exactly `inhibit_cycles` clocks.
  - Then go to REQ, asserting `ps2_dat_oe` = 1 (start bit 0) and `ps2_clk_oe` = 0 in the same cycle.
  - The timeout counter starts here.
- **REQ/SHIFT.**
  - On each `fall`, the bit counter n increments and the data line is updated:
    - n = 1..8: data bit n-1 (`ps2_dat_oe` = ~bit).
    - n = 9: parity.
    - n = 10: stop bit (`ps2_dat_oe` = 0).
  - After n = 10, go to ACK.
- **ACK.**
  - On the next `fall`, sample the filtered data line.
  - If it reads 0, go to WAITIDLE. If it reads 1, pulse `tx_error` and go to IDLE.
- **WAITIDLE.**
  - Wait until filtered clock and data are both 1.
  - Then pulse `tx_done` and go to IDLE.
- **Timeout.** If the timeout counter reaches `timeout_cycles` in REQ, SHIFT, ACK or WAITIDLE:
  - release both lines,
  - pulse `tx_error`,
  - go to IDLE.
- **Other rules.**
  - `tx_valid` is ignored outside IDLE. A held `tx_valid` after completion starts a new transfer.
  - Falling edges seen in IDLE or INHIBIT are ignored.

## Timing
- **Reset values.** `ps2_clk_oe`, `ps2_dat_oe`, `tx_done`, `tx_error` and `busy` are 0. `tx_ready` is 0 while `reset` is high and 1 from the first cycle after reset deasserts. State is IDLE.
- **Reset mid-transfer.** Both oe drop to 0 in the cycle after `reset` is sampled high. No done or error pulse is produced.
- **Acceptance.** `ps2_clk_oe` and `busy` rise, and `tx_ready` falls, one cycle after the accepting edge.
- **Edge latency.** Data changes one cycle after the `fall` strobe. The strobe itself lags the pin by 2 + `clock_filter` cycles.
- **Simultaneous timeout and `fall`.** Timeout wins.
- **Back-to-back transfers.** The minimum gap between transfers is one IDLE cycle.
- **Width rules.**
  - Counters are sized with `$clog2` of their parameter + 1.
  - The timeout counter saturates rather than wrapping.
  - The bit counter is 4 bits.

## Test plan
- **Reset.** Assert reset for 5 cycles while `tx_valid` = 1 -> oe both 0, `tx_ready` = 0 during reset and 1 on the first cycle after.
- **Normal send.**
  - Setup: `clock_filter` = 2, `inhibit_cycles` = 10, byte 0xED.
  - Expect `ps2_clk_oe` high for 10 cycles, then start bit.
  - Device model clocks 11 falls, sampling on rising edges -> bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - Device drives ACK 0, then releases -> one `tx_done` pulse, no `tx_error`.
- **Parity check.** Byte 0x00 -> parity bit 1. Byte 0x01 -> parity bit 0.
- **NACK.** Device returns ACK = 1 -> `tx_error` pulse, no `tx_done`, both oe 0 afterwards.
- **Timeout.** `timeout_cycles` = 500, device never clocks -> `tx_error` at 500 cycles after REQ entry, lines released.
- **Glitch and abort.**
  - A 1-cycle low glitch on `ps2_clk_in` with `clock_filter` = 2 -> no bit advance.
  - Reset asserted after bit 4 -> lines released, next transfer completes normally.
